// File: rtl/mfe_if.sv
`default_nettype none
// ============================================================================
// Module     : mfe_ifc (interface)
// Description: Sample-in / frame-result-out bundle for the streaming
//              minimum-finder engine. Optional macro MFE_MAX_EN adds the
//              signed-maximum result fields.
// Revision   : 1.0 - initial release
// ============================================================================
interface mfe_ifc #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_min;
  logic [IDX_W-1:0]  out_idx;
  logic [IDX_W:0]    out_len;
  logic              out_trunc;
`ifdef MFE_MAX_EN
  logic [DATA_W-1:0] out_max;
  logic [IDX_W-1:0]  out_max_idx;

  modport dut (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_idx, out_len, out_trunc,
    output out_max, out_max_idx
  );
`else
  modport dut (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_idx, out_len, out_trunc
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mfe.sv
`default_nettype none
// ============================================================================
// Module     : mfe
// Description: Streaming minimum-finder. Accepts signed samples until in_last
//              or until the frame reaches 2^IDX_W samples, then holds the
//              minimum, its earliest index, the frame length and a truncation
//              flag until the consumer handshakes.
//              Optional macro MFE_MAX_EN adds out_max / out_max_idx.
// Revision   : 1.0 - initial release
// ============================================================================
module mfe #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic   clk,
  input  logic   rst,
  mfe_ifc.dut    bus
);

  // Frame-length limit: a frame closes itself when this many samples arrive.
  localparam logic [IDX_W:0] c_max_len = {1'b1, {IDX_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Running accumulation for the frame in flight.
  logic signed [DATA_W-1:0] r_acc_min;
  logic [IDX_W-1:0]         r_acc_idx;
  logic [IDX_W:0]           r_count;

  // Result registers presented while holding.
  logic signed [DATA_W-1:0] r_out_min;
  logic [IDX_W-1:0]         r_out_idx;
  logic [IDX_W:0]           r_out_len;
  logic                     r_out_trunc;

  logic                     w_in_ready;
  logic                     w_out_valid;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_limit;
  logic                     w_close;
  logic                     w_done;
  logic [IDX_W:0]           w_new_count;
  logic [IDX_W-1:0]         w_pos;
  logic signed [DATA_W-1:0] w_smp;
  logic                     w_take_min;
  logic signed [DATA_W-1:0] w_min_nxt;
  logic [IDX_W-1:0]         w_idx_nxt;

  assign w_smp       = $signed(bus.in_data);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_first     = (r_state == S_IDLE);
  // Position of the incoming sample within its frame (zero-based).
  assign w_pos       = w_first ? '0 : r_count[IDX_W-1:0];
  assign w_new_count = w_first ? {{IDX_W{1'b0}}, 1'b1} : (r_count + 1'b1);
  assign w_limit     = (w_new_count == c_max_len);
  assign w_close     = w_accept & (bus.in_last | w_limit);
  assign w_done      = w_out_valid & bus.out_ready;

  // Strict comparison so that ties keep the earliest position.
  assign w_take_min  = w_first | (w_smp < r_acc_min);
  assign w_min_nxt   = w_take_min ? w_smp : r_acc_min;
  assign w_idx_nxt   = w_take_min ? w_pos : r_acc_idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = w_close ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_close) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulate the running minimum and sample count; clear count between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_min <= '0;
      r_acc_idx <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_acc_min <= w_min_nxt;
      r_acc_idx <= w_idx_nxt;
      r_count   <= w_new_count;
    end else if (w_done) begin
      r_count   <= '0;
    end
  end

  // Capture the frame result on the closing sample; it stays put while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_min   <= '0;
      r_out_idx   <= '0;
      r_out_len   <= '0;
      r_out_trunc <= 1'b0;
    end else if (w_close) begin
      r_out_min   <= w_min_nxt;
      r_out_idx   <= w_idx_nxt;
      r_out_len   <= w_new_count;
      r_out_trunc <= w_limit;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_min   = r_out_min;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_len   = r_out_len;
  assign bus.out_trunc = r_out_trunc;

`ifdef MFE_MAX_EN
  logic signed [DATA_W-1:0] r_acc_max;
  logic [IDX_W-1:0]         r_acc_max_idx;
  logic signed [DATA_W-1:0] r_out_max;
  logic [IDX_W-1:0]         r_out_max_idx;
  logic                     w_take_max;
  logic signed [DATA_W-1:0] w_max_nxt;
  logic [IDX_W-1:0]         w_max_idx_nxt;

  assign w_take_max    = w_first | (w_smp > r_acc_max);
  assign w_max_nxt     = w_take_max ? w_smp : r_acc_max;
  assign w_max_idx_nxt = w_take_max ? w_pos : r_acc_max_idx;

  // Running maximum, tracked alongside the minimum with the same tie rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_max     <= '0;
      r_acc_max_idx <= '0;
    end else if (w_accept) begin
      r_acc_max     <= w_max_nxt;
      r_acc_max_idx <= w_max_idx_nxt;
    end
  end

  // Maximum result captured together with the minimum result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_max     <= '0;
      r_out_max_idx <= '0;
    end else if (w_close) begin
      r_out_max     <= w_max_nxt;
      r_out_max_idx <= w_max_idx_nxt;
    end
  end

  assign bus.out_max     = r_out_max;
  assign bus.out_max_idx = r_out_max_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfe.sv
`default_nettype none
// ============================================================================
// Module     : tb_mfe
// Description: Scoreboard bench for mfe. Stimulus pushes expected frame
//              results (computed from the collected frame samples) into a
//              queue; a monitor compares them whenever out_valid is high.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mfe;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 8;
  localparam int MAXLEN = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mfe_ifc #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifc ();

  mfe #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    int mn;
    int idx;
    int len;
    int trunc;
    int mx;
    int mx_idx;
  } exp_t;

  exp_t sb[$];
  int   frame_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: minimum/maximum of the whole frame, then the first place it occurs.
  function automatic void close_frame(input int trunc);
    exp_t e;
    int lo, hi;
    lo = frame_q[0];
    hi = frame_q[0];
    foreach (frame_q[i]) begin
      if (frame_q[i] < lo) lo = frame_q[i];
      if (frame_q[i] > hi) hi = frame_q[i];
    end
    e.mn = lo; e.mx = hi; e.idx = -1; e.mx_idx = -1;
    foreach (frame_q[i]) begin
      if (e.idx < 0 && frame_q[i] == lo) e.idx = i;
      if (e.mx_idx < 0 && frame_q[i] == hi) e.mx_idx = i;
    end
    e.len   = frame_q.size();
    e.trunc = trunc;
    sb.push_back(e);
    frame_q.delete();
  endfunction

  task automatic check_reset_vals();
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_min",   ifc.out_min,   0);
    chk("rst_out_idx",   ifc.out_idx,   0);
    chk("rst_out_len",   ifc.out_len,   0);
    chk("rst_out_trunc", ifc.out_trunc, 0);
`ifdef MFE_MAX_EN
    chk("rst_out_max",     ifc.out_max,     0);
    chk("rst_out_max_idx", ifc.out_max_idx, 0);
`endif
  endtask

  // Entered and left at posedge+1. Holds the sample until the engine takes it.
  task automatic send(input int d, input bit last, input int gap);
    logic signed [DATA_W-1:0] s;
    bit acc, done_s, closed;
    s = d[DATA_W-1:0];
    ifc.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    ifc.in_valid = 1'b1;
    ifc.in_data  = s;
    ifc.in_last  = last;
    done_s = 1'b0;
    for (int t = 0; t < 300 && !done_s; t++) begin
      chk("in_ready", ifc.in_ready, (sb.size() == 0));
      acc    = (sb.size() == 0);
      closed = 1'b0;
      @(posedge clk);
      if (acc) begin
        frame_q.push_back(int'(s));
        if (last || frame_q.size() == MAXLEN) begin
          close_frame(frame_q.size() == MAXLEN);
          closed = 1'b1;
        end
        done_s = 1'b1;
      end
      #1;
      if (closed) chk("latency_out_valid", ifc.out_valid, 1);
    end
    if (!done_s) chk("send_timeout", done_s, 1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check_reset_vals();
    sb.delete();
    frame_q.delete();
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Consumer ready pattern.
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ifc.out_ready = 1'b1;
        1:       ifc.out_ready = ($urandom_range(0, 3) != 0);
        default: ifc.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every cycle a result is shown it must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ifc.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", ifc.out_valid, 0);
        end else begin
          chk("out_min",   longint'($signed(ifc.out_min)), sb[0].mn);
          chk("out_idx",   ifc.out_idx,   sb[0].idx);
          chk("out_len",   ifc.out_len,   sb[0].len);
          chk("out_trunc", ifc.out_trunc, sb[0].trunc);
`ifdef MFE_MAX_EN
          chk("out_max",     longint'($signed(ifc.out_max)), sb[0].mx);
          chk("out_max_idx", ifc.out_max_idx, sb[0].mx_idx);
`endif
          if (ifc.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int n, d, g;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    ifc.in_last  = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", ifc.in_ready, 1);

    // Basic frame with a tie on the minimum.
    rdy_mode = 0;
    send(5, 0, 0); send(-3, 0, 0); send(7, 0, 0); send(-3, 1, 0);

    // Single most-negative sample.
    send(-32768, 1, 0);

    // Length-limited frame, then the next sample opens a fresh frame.
    for (int i = 0; i < MAXLEN; i++) send(100 + i, 0, 0);
    send(50, 1, 0);

    // Max-tracking frame (min side checked in every build).
    send(4, 0, 0); send(9, 0, 0); send(9, 0, 0); send(1, 1, 0);

    // Consumer stalls while upstream keeps offering a sample.
    rdy_mode = 2;
    @(posedge clk); #1;
    send(3, 0, 0); send(1, 1, 0);
    fork
      send(7, 1, 0);
      begin repeat (10) @(posedge clk); rdy_mode = 0; end
    join

    // Reset mid-frame discards it.
    send(10, 0, 0); send(20, 0, 0); send(30, 0, 0);
    pulse_reset();
    send(9, 0, 0); send(2, 1, 0);

    // Reset while a result is pending discards it.
    rdy_mode = 2;
    @(posedge clk); #1;
    send(-5, 1, 0);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset();

    // Randomized frames with random gaps and random consumer back-pressure.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) != 0) d = int'($urandom_range(0, 6)) - 3;
        else d = int'($urandom);
        g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        send(d, (k == n - 1), g);
      end
    end

    rdy_mode = 0;
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
